priority_encoder_pipe: RTL

- Parametrised N-to-log2(N) encoder with a registered output stage and a valid/ready handshake on both sides.
- Replaces fixed 4x2 one-hot encoders wherever request vectors must be turned into an index, e.g. interrupt select or arbitration grant index.
- Handles multi-hot and all-zero inputs deterministically.
- Two modes: fixed priority, or round-robin using an internal rotating pointer.

---
 rtl/priority_encoder_pipe.sv | 118 +++++++++++
 1 files changed

// File: rtl/priority_encoder_pipe.sv
// Pipelined priority encoder with valid/ready on both sides; fixed-priority or round-robin search.
// Optional macro ENC_MULTIHOT_CHK_EN adds a registered out_multi flag (two or more requests seen).
module priority_encoder_pipe #(
   parameter int WIDTH      = 8,
   parameter int MODE       = 0,
   parameter int LSB_FIRST  = 1,
   localparam int IDX_W     = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [IDX_W-1:0] out,
   output logic             out_none,
   output logic             out_valid,
`ifdef ENC_MULTIHOT_CHK_EN
   output logic             out_multi,
`endif
   input  logic             out_ready
);

   logic [IDX_W-1:0] outIdx_q;
   logic             outNone_q;
   logic             outValid_q;
   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] ptr_d;
   logic [IDX_W-1:0] encIdx;
   logic [IDX_W-1:0] rotOffset;
   logic [IDX_W:0]   rotSum;
   logic [WIDTH-1:0] rotVec;
   logic             anyReq;
   logic             accept;

   assign anyReq   = |in;
   assign in_ready = !outValid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // Round-robin: rotate so ptr lands on bit 0, find the lowest set bit, then map back modulo WIDTH.
   always_comb begin
      rotVec    = WIDTH'({in, in} >> ptr_q);
      rotOffset = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (rotVec[i]) rotOffset = IDX_W'(i);
      end
      rotSum = {1'b0, ptr_q} + {1'b0, rotOffset};
      if (rotSum >= (IDX_W+1)'(WIDTH)) rotSum = rotSum - (IDX_W+1)'(WIDTH);
   end

   always_comb begin
      encIdx = '0;
      if (MODE == 1) begin
         encIdx = rotSum[IDX_W-1:0];
      end else if (LSB_FIRST != 0) begin
         for (int i = WIDTH - 1; i >= 0; i--) begin
            if (in[i]) encIdx = IDX_W'(i);
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (in[i]) encIdx = IDX_W'(i);
         end
      end
      if (!anyReq) encIdx = '0;
   end

   // The pointer wraps at WIDTH-1, not at the top of its binary range.
   always_comb begin
      ptr_d = ptr_q;
      if (MODE == 1 && accept && anyReq) begin
         ptr_d = (encIdx == IDX_W'(WIDTH - 1)) ? '0 : encIdx + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outIdx_q   <= '0;
         outNone_q  <= 1'b0;
         outValid_q <= 1'b0;
      end else if (accept) begin
         outIdx_q   <= encIdx;
         outNone_q  <= !anyReq;
         outValid_q <= 1'b1;
      end else if (out_ready) begin
         outValid_q <= 1'b0;
      end
   end

`ifdef ENC_MULTIHOT_CHK_EN
   logic outMulti_q;
   logic multiHot;

   // Clearing the lowest set bit leaves something only when two or more bits were set.
   assign multiHot = |(in & (in - 1'b1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outMulti_q <= 1'b0;
      end else if (accept) begin
         outMulti_q <= multiHot;
      end
   end

   assign out_multi = outMulti_q;
`endif

   assign out       = outIdx_q;
   assign out_none  = outNone_q;
   assign out_valid = outValid_q;

endmodule
